stream_binarizer: RTL and testbench

Pixel-stream reader for `threshold_rom`: accepts raster-order 8-bit grayscale pixels with a valid/ready handshake, fetches each pixel's per-position threshold from the ROM, and emits one binary pixel per input pixel. It sits between the pixel source (camera/frame reader) and the display/output writer. It is the ROM's only read client and owns its address port, so it must absorb the ROM's one-cycle read latency under backpressure.

---
 rtl/stream_binarizer.sv | 142 ++++++++++++++
 tb/tb_stream_binarizer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_binarizer.sv
// Pixel-stream binarizer: compares each raster-order pixel against its per-position threshold
// read from threshold_rom, absorbing the ROM's one-cycle read latency under backpressure.
module stream_binarizer #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_pixel,
    input  logic              in_sof,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_sof,
    output logic              out_eof,
    output logic              sync_err
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] OneIdx  = ADDR_W'(1);

    // Position of the next pixel to accept
    logic [ADDR_W-1:0] pos_q, pos_d;

    // Stage 1: pixel waiting for its ROM read
    logic              s1_valid_q, s1_valid_d;
    logic [7:0]        s1_pixel_q, s1_pixel_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              s1_sof_q, s1_sof_d;
    logic              s1_eof_q, s1_eof_d;

    // Output register
    logic out_valid_q, out_valid_d;
    logic out_bit_q, out_bit_d;
    logic out_sof_q, out_sof_d;
    logic out_eof_q, out_eof_d;

    logic sync_err_q, sync_err_d;

    logic              acc;
    logic              adv;
    logic              resync;
    logic [ADDR_W-1:0] idx;
    logic              idx_last;

    always_comb begin
        adv      = s1_valid_q & (~out_valid_q | out_ready);
        in_ready = ~rst & (~s1_valid_q | ~out_valid_q | out_ready);
        acc      = in_valid & in_ready;
        // A start-of-frame marker mid-frame restarts the raster at index 0
        resync   = acc & in_sof & (pos_q != '0);
        idx      = resync ? '0 : pos_q;
        idx_last = (idx == LastIdx);
        // Holding the stage-1 address while idle keeps rom_q valid across stalls
        rom_addr = acc ? idx : s1_addr_q;
    end

    always_comb begin
        pos_d = pos_q;
        if (acc) begin
            if (idx_last) begin
                pos_d = '0;
            end else begin
                pos_d = idx + OneIdx;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pixel_d = s1_pixel_q;
        s1_addr_d  = s1_addr_q;
        s1_sof_d   = s1_sof_q;
        s1_eof_d   = s1_eof_q;
        if (acc) begin
            s1_valid_d = 1'b1;
            s1_pixel_d = in_pixel;
            s1_addr_d  = idx;
            s1_sof_d   = (idx == '0);
            s1_eof_d   = idx_last;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        if (adv) begin
            out_valid_d = 1'b1;
            out_bit_d   = (s1_pixel_q >= rom_q);
            out_sof_d   = s1_sof_q;
            out_eof_d   = s1_eof_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign sync_err_d = resync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_pixel_q  <= '0;
            s1_addr_q   <= '0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            s1_valid_q  <= s1_valid_d;
            s1_pixel_q  <= s1_pixel_d;
            s1_addr_q   <= s1_addr_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_stream_binarizer.sv
// Directed bench for stream_binarizer: a full-size instance for streaming, backpressure,
// resync, reset and compare tests, and a 4x2 instance for frame wrap.
module tb_stream_binarizer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = 8'h00;
    logic        in_sof = 1'b0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_q;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_bit;
    logic        out_sof;
    logic        out_eof;
    logic        sync_err;

    stream_binarizer #(.WIDTH(256), .HEIGHT(256), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .sync_err  (sync_err)
    );

    always @(posedge clk) rom_q <= rom_addr[7:0];

    // 4x2 instance for frame wrap
    logic       w_in_valid = 1'b0;
    logic       w_in_ready;
    logic [7:0] w_in_pixel = 8'h03;
    logic       w_in_sof = 1'b0;
    logic [2:0] w_rom_addr;
    logic [7:0] w_rom_q;
    logic       w_out_valid;
    logic       w_out_ready = 1'b1;
    logic       w_out_bit;
    logic       w_out_sof;
    logic       w_out_eof;
    logic       w_sync_err;

    stream_binarizer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_pixel  (w_in_pixel),
        .in_sof    (w_in_sof),
        .rom_addr  (w_rom_addr),
        .rom_q     (w_rom_q),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_bit   (w_out_bit),
        .out_sof   (w_out_sof),
        .out_eof   (w_out_eof),
        .sync_err  (w_sync_err)
    );

    always @(posedge clk) w_rom_q <= {5'b0, w_rom_addr};

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        b;
        logic        sof;
        logic        eof;
        logic [15:0] addr;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] exp_pos = 16'h0;
    logic [15:0] m_idx;
    logic        m_resync;
    logic        m_st1;
    logic        bp = 1'b0;
    int          pop_cnt = 0;
    int          sof_cnt = 0;
    int          one_cnt = 0;
    int          sync_cnt = 0;
    int          stall_cnt = 0;
    logic        last_bit = 1'b0;

    // Reference model and scoreboard for the full-size instance, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            m_st1 = (q.size() == 2) || (q.size() == 1 && !out_valid);
            if (m_st1 && !(in_valid && in_ready))
                check("rom_hold", rom_addr, q[q.size()-1].addr);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stale_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_bit", out_bit, e.b);
                    check("out_sof", out_sof, e.sof);
                    check("out_eof", out_eof, e.eof);
                end
                pop_cnt++;
                last_bit = out_bit;
                if (out_sof) sof_cnt++;
                if (out_bit) one_cnt++;
            end
            if (in_valid && in_ready) begin
                m_resync = in_sof && (exp_pos != 16'h0);
                m_idx = m_resync ? 16'h0 : exp_pos;
                check("rom_addr", rom_addr, m_idx);
                e.b    = (in_pixel >= m_idx[7:0]);
                e.sof  = (m_idx == 16'h0);
                e.eof  = (m_idx == 16'hFFFF);
                e.addr = m_idx;
                q.push_back(e);
                exp_pos = m_resync ? 16'h1 : ((m_idx == 16'hFFFF) ? 16'h0 : m_idx + 16'h1);
            end
            if (sync_err) sync_cnt++;
        end
    end

    // Hand-computed frame-wrap tables, bit i is output i+1 (pixel 3 vs threshold a)
    logic [16:0] wrap_sof_tbl = 17'b1_0000_0001_0000_0001;
    logic [16:0] wrap_eof_tbl = 17'b0_1000_0000_1000_0000;
    logic [16:0] wrap_bit_tbl = 17'b1_0000_1111_0000_1111;
    logic        w_en = 1'b0;
    int          w_acc_n = 0;
    int          w_out_n = 0;

    always @(negedge clk) begin
        if (!rst && w_en) begin
            if (w_in_valid && w_in_ready) begin
                check("wrap_addr", w_rom_addr, w_acc_n % 8);
                w_acc_n++;
            end
            if (w_out_valid && w_out_ready && w_out_n < 17) begin
                check("wrap_sof", w_out_sof, wrap_sof_tbl[w_out_n]);
                check("wrap_eof", w_out_eof, wrap_eof_tbl[w_out_n]);
                check("wrap_bit", w_out_bit, wrap_bit_tbl[w_out_n]);
                w_out_n++;
            end
        end
    end

    task automatic send(input logic [7:0] px, input logic sof);
        int n = 0;
        in_valid = 1'b1;
        in_pixel = px;
        in_sof   = sof;
        if (bp) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(posedge clk);
            #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            stall_cnt++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        exp_pos = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pop_cnt = 0;
        sof_cnt = 0;
        one_cnt = 0;
        sync_cnt = 0;
        stall_cnt = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_rom_addr", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Frame wrap on the 4x2 instance, no in_sof at all
        w_en = 1'b1;
        w_in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (w_acc_n >= 17) break;
        end
        w_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("wrap_in_count", w_acc_n, 17);
        check("wrap_out_count", w_out_n, 17);
        w_en = 1'b0;

        // Streaming with out_ready high: full throughput, 2-cycle latency
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'h80, i == 0);
            if (i == 0) check("lat_first", out_valid, 0);
            if (i == 1) check("lat_second", out_valid, 1);
        end
        drain();
        check("stream_count", pop_cnt, 300);
        check("stream_sof_count", sof_cnt, 1);
        check("stream_stalls", stall_cnt, 0);
        check("stream_sync", sync_cnt, 0);

        // Random backpressure: pixel = index+1, every result is 1
        do_reset();
        bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] px;
            px = 8'(i + 1);
            send(px, i == 0);
        end
        bp = 1'b0;
        drain();
        check("bp_count", pop_cnt, 100);
        check("bp_ones", one_cnt, 100);

        // Resync: in_sof on the 5th pixel of a frame
        do_reset();
        out_ready = 1'b1;
        send(8'h10, 1'b1);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h20, 1'b1);
        send(8'h30, 1'b0);
        drain();
        check("resync_pulses", sync_cnt, 1);
        check("resync_sof_count", sof_cnt, 2);
        check("resync_count", pop_cnt, 6);

        // Reset with 2 pixels in flight
        do_reset();
        out_ready = 1'b0;
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_rom_addr", rom_addr, 0);
        q.delete();
        exp_pos = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pop_cnt = 0;
        #1;
        check("postrst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        drain();
        check("postrst_count", pop_cnt, 3);

        // Equal compare at index 5
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h00, i == 0);
        send(8'h05, 1'b0);
        drain();
        check("eq_hit", last_bit, 1);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h00, i == 0);
        send(8'h04, 1'b0);
        drain();
        check("eq_miss", last_bit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
